// File: rtl/slow_tick_bcd_counter.sv
// Four-digit BCD tick counter: synchronises slow_clk, turns its rising edges into ticks, counts them under start/stop/clear.
// Optional BCD_DOWN_EN adds a 'down' input for decrementing; outputs are registered, 1-cycle tick/overflow pulses.
module slow_tick_bcd_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int WRAP        = 1
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
`ifdef BCD_DOWN_EN
  input  logic        down,
`endif
  output logic [15:0] bcd,
  output logic        running,
  output logic        tick,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [15:0]            cnt_q, cnt_d;
  logic                   running_q, running_d;
  logic                   tick_q, tick_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_det;
  logic                   count_en;
  logic                   terminal;
  logic                   dn;

`ifdef BCD_DOWN_EN
  assign dn = down;
`else
  assign dn = 1'b0;
`endif

  // Ripple one step through the digits; 9999+1 and 0000-1 roll over naturally.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic dec);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (!dec) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign count_en = (state_q == RUN) && edge_det && !clear && !stop;
  assign terminal = dn ? (cnt_q == 16'h0000) : (cnt_q == 16'h9999);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    tick_d  = edge_det;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = 16'h0000;
    end else if (stop) begin
      // stop outranks start even outside RUN, where it simply holds the state
      if (state_q == RUN) state_d = HALT;
    end else if (start && state_q != RUN) begin
      state_d = RUN;
    end else if (count_en) begin
      if (terminal) begin
        ovf_d = 1'b1;
        if (WRAP != 0) cnt_d = bcd_step(cnt_q, dn);
        else           state_d = HALT;
      end else begin
        cnt_d = bcd_step(cnt_q, dn);
      end
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= 16'h0000;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      hist_q    <= sync_q[SYNC_STAGES-1];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bcd      = cnt_q;
  assign running  = running_q;
  assign tick     = tick_q;
  assign overflow = ovf_q;

endmodule
